// File: rtl/fetch_unit.sv
// Instruction fetch and PC sequencing: a two-state req/valid loop that owns the
// PC, holds the fetched word for the controller and counts retired instructions.
module fetch_unit #(
  parameter int             N        = 32,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_rdata,
  input  logic         imem_ready,
  input  logic         stall,
  input  logic         pcsrc,
  input  logic         jump,
  output logic [N-1:0] instr,
  output logic [4:0]   op,
  output logic         instr_valid,
  output logic [N-1:0] pc,
  output logic [N-1:0] pc_plus4,
  output logic [N-1:0] retired_count
);

  localparam logic [0:0]   S_REQ      = 1'b0;
  localparam logic [0:0]   S_VALID    = 1'b1;
  localparam logic [N-1:0] RESET_PC_W = {RESET_PC[N-1:2], 2'b00};

  logic [0:0]   state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] instr_q, instr_d;
  logic [N-1:0] retired_q, retired_d;
  logic [N-1:0] branch_target;
  logic [N-1:0] jump_target;
  logic [N-1:0] next_pc;

  assign pc_plus4      = pc_q + {{(N-3){1'b0}}, 3'b100};
  assign branch_target = pc_plus4 + {{(N-18){instr_q[15]}}, instr_q[15:0], 2'b00};
  assign jump_target   = {pc_plus4[N-1:29], instr_q[26:0], 2'b00};

  // jump has priority over a taken branch
  always_comb begin
    if (jump) begin
      next_pc = jump_target;
    end else if (pcsrc) begin
      next_pc = branch_target;
    end else begin
      next_pc = pc_plus4;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      S_REQ: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = S_VALID;
        end else begin
          state_d = S_REQ;
        end
      end
      S_VALID: begin
        if (!stall) begin
          pc_d      = next_pc;
          retired_d = retired_q + {{(N-1){1'b0}}, 1'b1};
          state_d   = S_REQ;
        end else begin
          state_d = S_VALID;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC_W;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // handshake flags are forced low during reset so no stale request escapes
  assign imem_req      = ~reset & (state_q == S_REQ);
  assign instr_valid   = ~reset & (state_q == S_VALID);
  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign instr         = instr_q;
  assign op            = instr_q[31:27];
  assign retired_count = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected fetch addresses and
// expected held-instruction records; a monitor pops and compares them.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        pcsrc;
  logic        jump;
  logic [31:0] instr;
  logic [4:0]  op;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
    logic [31:0] ret;
  } valid_rec_t;

  logic [31:0] exp_addr_q[$];
  valid_rec_t  exp_valid_q[$];

  fetch_unit #(.N(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .stall(stall),
    .pcsrc(pcsrc), .jump(jump), .instr(instr), .op(op),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compare accepted fetches and consumed instructions against the scoreboard
  always @(negedge clk) begin
    valid_rec_t r;
    logic [31:0] a;
    if (!reset && imem_req && imem_ready) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
      end else begin
        a = exp_addr_q.pop_front();
        check("fetch_addr", imem_addr, a);
      end
    end
    if (!reset && instr_valid && !stall) begin
      if (exp_valid_q.size() == 0) begin
        check("unexpected_valid", instr, 32'hFFFF_FFFF);
      end else begin
        r = exp_valid_q.pop_front();
        check("instr", instr, r.word);
        check("op", {27'd0, op}, {27'd0, r.word[31:27]});
        check("pc", pc, r.pc);
        check("pc_plus4", pc_plus4, r.pc + 32'd4);
        check("retired", retired_count, r.ret);
      end
    end
  end

  task automatic do_fetch(input logic [31:0] word, input logic [31:0] exp_pc,
                          input logic [31:0] exp_ret, input logic pcs, input logic jmp);
    exp_addr_q.push_back(exp_pc);
    exp_valid_q.push_back('{word: word, pc: exp_pc, ret: exp_ret});
    imem_ready = 1'b1;
    imem_rdata = word;
    pcsrc = 1'b0;
    jump  = 1'b0;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    pcsrc = pcs;
    jump  = jmp;
    @(posedge clk); #1;
    pcsrc = 1'b0;
    jump  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'd0;
    stall = 1'b0; pcsrc = 1'b0; jump = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_retired", retired_count, 32'h0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    reset = 1'b0;

    // sequential fetches at 0x0, 0x4, 0x8
    do_fetch(32'h0000_0000, 32'h0, 32'd0, 1'b0, 1'b0);
    do_fetch(32'h1111_0001, 32'h4, 32'd1, 1'b0, 1'b0);
    do_fetch(32'h2222_0002, 32'h8, 32'd2, 1'b0, 1'b0);
    check("retired_after3", retired_count, 32'd3);
    do_fetch(32'h1000_0000, 32'hC, 32'd3, 1'b0, 1'b0);
    // backward branch from 0x10 to 0x0C
    do_fetch(32'h0800_FFFE, 32'h10, 32'd4, 1'b1, 1'b0);
    // forward branch 0x0C -> 0x20
    do_fetch(32'h0800_0004, 32'hC, 32'd5, 1'b1, 1'b0);
    // jump beats branch: 0x20 -> 0x100 (branch would give 0x124)
    do_fetch(32'hF800_0040, 32'h20, 32'd6, 1'b1, 1'b1);

    // backpressure at 0x100; control inputs must be ignored in S_REQ
    pcsrc = 1'b1; jump = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("bp_req", {31'd0, imem_req}, 32'd1);
      check("bp_addr", imem_addr, 32'h100);
      check("bp_valid", {31'd0, instr_valid}, 32'd0);
    end
    pcsrc = 1'b0; jump = 1'b0;

    // fetch branch word at 0x100 targeting 0xFFFFFFFC, stalled for 3 cycles first
    exp_addr_q.push_back(32'h100);
    exp_valid_q.push_back('{word: 32'h0800_FFBE, pc: 32'h100, ret: 32'd7});
    imem_ready = 1'b1; imem_rdata = 32'h0800_FFBE;
    @(posedge clk); #1;
    stall = 1'b1; pcsrc = 1'b1; jump = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_pc", pc, 32'h100);
      check("stall_instr", instr, 32'h0800_FFBE);
      check("stall_retired", retired_count, 32'd7);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    imem_ready = 1'b0; stall = 1'b0; jump = 1'b0;
    @(posedge clk); #1;
    pcsrc = 1'b0;
    check("branch_to_top", pc, 32'hFFFF_FFFC);

    // sequential wrap 0xFFFFFFFC -> 0x0
    do_fetch(32'h0000_0000, 32'hFFFF_FFFC, 32'd8, 1'b0, 1'b0);
    check("wrap_pc", pc, 32'h0);

    // reset in S_REQ while ready arrives: data discarded
    reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("rstmid_instr", instr, 32'h0);
    check("rstmid_pc", pc, 32'h0);
    check("rstmid_retired", retired_count, 32'd0);
    check("rstmid_req", {31'd0, imem_req}, 32'd0);
    reset = 1'b0; imem_ready = 1'b0;
    @(posedge clk); #1;
    check("post_rst_req", {31'd0, imem_req}, 32'd1);
    check("post_rst_addr", imem_addr, 32'h0);
    do_fetch(32'h1234_5678, 32'h0, 32'd0, 1'b0, 1'b0);
    check("post_rst_retired", retired_count, 32'd1);

    check("addr_q_empty", exp_addr_q.size(), 32'd0);
    check("valid_q_empty", exp_valid_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
